// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and LSU write-back.
// LSU has fixed priority; a starvation counter forces an ALU win after repeated losses.
module regfile_wb_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int STARVE_LIMIT = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              alu_valid_i,
  output logic              alu_ready_o,
  input  logic [ADDR_W-1:0] alu_rd_i,
  input  logic [DATA_W-1:0] alu_data_i,
  input  logic              lsu_valid_i,
  output logic              lsu_ready_o,
  input  logic [ADDR_W-1:0] lsu_rd_i,
  input  logic [DATA_W-1:0] lsu_data_i,
  output logic              rf_we_o,
  output logic [ADDR_W-1:0] rf_wr_addr_o,
  output logic [DATA_W-1:0] rf_wr_data_o,
  output logic              wb_src_o
);

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  logic              aluGrant;
  logic              lsuGrant;
  logic [3:0]        starveCnt_q, starveCnt_d;
  logic              rfWe_q, rfWe_d;
  logic [ADDR_W-1:0] rfAddr_q, rfAddr_d;
  logic [DATA_W-1:0] rfData_q, rfData_d;
  logic              wbSrc_q, wbSrc_d;

  // Ready never looks downstream: the write port is free every cycle.
  always_comb begin
    aluGrant = 1'b0;
    lsuGrant = 1'b0;
    if (!flush_i) begin
      if (alu_valid_i && lsu_valid_i) begin
        if (starveCnt_q == StarveLimit) begin
          aluGrant = 1'b1;
        end else begin
          lsuGrant = 1'b1;
        end
      end else begin
        aluGrant = alu_valid_i;
        lsuGrant = lsu_valid_i;
      end
    end
  end

  assign alu_ready_o = aluGrant;
  assign lsu_ready_o = lsuGrant;

  always_comb begin
    starveCnt_d = starveCnt_q;
    if (flush_i || aluGrant || !alu_valid_i) begin
      starveCnt_d = 4'd0;
    end else if (lsuGrant) begin
      starveCnt_d = (starveCnt_q >= StarveLimit) ? StarveLimit : starveCnt_q + 4'd1;
    end
  end

  // A write to x0 is still consumed, but never reaches the register file.
  always_comb begin
    rfWe_d   = 1'b0;
    rfAddr_d = rfAddr_q;
    rfData_d = rfData_q;
    wbSrc_d  = wbSrc_q;
    if (aluGrant) begin
      rfWe_d   = (alu_rd_i != '0);
      rfAddr_d = alu_rd_i;
      rfData_d = alu_data_i;
      wbSrc_d  = 1'b0;
    end else if (lsuGrant) begin
      rfWe_d   = (lsu_rd_i != '0);
      rfAddr_d = lsu_rd_i;
      rfData_d = lsu_data_i;
      wbSrc_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starveCnt_q <= 4'd0;
      rfWe_q      <= 1'b0;
      rfAddr_q    <= '0;
      rfData_q    <= '0;
      wbSrc_q     <= 1'b0;
    end else begin
      starveCnt_q <= starveCnt_d;
      rfWe_q      <= rfWe_d;
      rfAddr_q    <= rfAddr_d;
      rfData_q    <= rfData_d;
      wbSrc_q     <= wbSrc_d;
    end
  end

  assign rf_we_o      = rfWe_q;
  assign rf_wr_addr_o = rfAddr_q;
  assign rf_wr_data_o = rfData_q;
  assign wb_src_o     = wbSrc_q;

  // Sources must hold a pending request unchanged until it is accepted.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(alu_ready_o && lsu_ready_o));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (alu_valid_i && !alu_ready_o) |=> (alu_valid_i && $stable(alu_rd_i) && $stable(alu_data_i)));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (lsu_valid_i && !lsu_ready_o) |=> (lsu_valid_i && $stable(lsu_rd_i) && $stable(lsu_data_i)));

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference grant model pushes expected
// writes when requests are driven, and they are popped when the write port updates.
module tb_regfile_wb_arbiter;

  localparam int DATA_W       = 32;
  localparam int ADDR_W       = 5;
  localparam int STARVE_LIMIT = 3;

  typedef struct {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
    logic              src;
  } wbEntry_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [ADDR_W-1:0] alu_rd, lsu_rd;
  logic [DATA_W-1:0] alu_data, lsu_data;
  logic              rf_we, wb_src;
  logic [ADDR_W-1:0] rf_wr_addr;
  logic [DATA_W-1:0] rf_wr_data;

  wbEntry_t          scoreQ[$];
  int                testsRun = 0;
  int                testsFailed = 0;
  int                mStarve = 0;
  int                aluWins = 0;
  logic              lastAlu, lastLsu;
  logic [ADDR_W-1:0] expAddr = '0;
  logic [DATA_W-1:0] expData = '0;
  logic              expSrc = 1'b0;
  logic [DATA_W-1:0] rfArr [32];

  regfile_wb_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .alu_valid_i(alu_valid), .alu_ready_o(alu_ready), .alu_rd_i(alu_rd), .alu_data_i(alu_data),
    .lsu_valid_i(lsu_valid), .lsu_ready_o(lsu_ready), .lsu_rd_i(lsu_rd), .lsu_data_i(lsu_data),
    .rf_we_o(rf_we), .rf_wr_addr_o(rf_wr_addr), .rf_wr_data_o(rf_wr_data), .wb_src_o(wb_src)
  );

  always #5 clk = ~clk;

  // Stand-in for the register file that the write port feeds.
  always @(posedge clk) begin
    if (rst_n && rf_we) rfArr[rf_wr_addr] <= rf_wr_data;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests, check ready against the model, then check the write port.
  task automatic applyStimulus(input logic av, input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] ad,
                               input logic lv, input logic [ADDR_W-1:0] lrd, input logic [DATA_W-1:0] ld,
                               input logic fl);
    logic gA, gL;
    wbEntry_t e;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    flush = fl;
    @(negedge clk);
    gA = 1'b0; gL = 1'b0;
    if (!fl) begin
      if (av && lv) begin
        if (mStarve == STARVE_LIMIT) gA = 1'b1; else gL = 1'b1;
      end else begin
        gA = av; gL = lv;
      end
    end
    checkOutput("alu_ready", 64'(alu_ready), 64'(gA));
    checkOutput("lsu_ready", 64'(lsu_ready), 64'(gL));
    if (gA) scoreQ.push_back('{rd: ard, data: ad, src: 1'b0});
    else if (gL) scoreQ.push_back('{rd: lrd, data: ld, src: 1'b1});
    if (fl || gA || !av) mStarve = 0;
    else if (gL && mStarve < STARVE_LIMIT) mStarve++;
    lastAlu = gA; lastLsu = gL;
    if (gA) aluWins++;
    @(posedge clk);
    #1;
    if (scoreQ.size() > 0) begin
      e = scoreQ.pop_front();
      expAddr = e.rd; expData = e.data; expSrc = e.src;
      checkOutput("rf_we", 64'(rf_we), 64'(e.rd != 0));
    end else begin
      checkOutput("rf_we_idle", 64'(rf_we), 64'd0);
    end
    checkOutput("rf_wr_addr", 64'(rf_wr_addr), 64'(expAddr));
    checkOutput("rf_wr_data", 64'(rf_wr_data), 64'(expData));
    checkOutput("wb_src", 64'(wb_src), 64'(expSrc));
  endtask

  task automatic idle();
    applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [ADDR_W-1:0] ar, lr;
    logic [DATA_W-1:0] ad, ld;
    logic w1, w2;
    int maxWait, curWait;

    rst_n = 1'b0; flush = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    #12;
    checkOutput("reset_we", 64'(rf_we), 64'd0);
    checkOutput("reset_addr", 64'(rf_wr_addr), 64'd0);
    checkOutput("reset_data", 64'(rf_wr_data), 64'd0);
    checkOutput("reset_src", 64'(wb_src), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single ALU write
    applyStimulus(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0);
    checkOutput("t2_addr7", 64'(rf_wr_addr), 64'd7);
    idle();

    // LSU write to x0 is consumed without a write enable
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd0, 32'h1234, 1'b0);
    checkOutput("t4_we0", 64'(rf_we), 64'd0);
    checkOutput("t4_src", 64'(wb_src), 64'd1);
    idle();

    // Both valid every cycle: LSU x3 then ALU, repeating
    aluWins = 0; maxWait = 0; curWait = 0;
    ar = 5'd1; ad = $urandom; lr = 5'd2; ld = $urandom;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, ar, ad, 1'b1, lr, ld, 1'b0);
      if (lastAlu) begin
        ar = 5'($urandom_range(1, 31)); ad = $urandom; curWait = 0;
      end else begin
        curWait++;
        if (curWait > maxWait) maxWait = curWait;
      end
      if (lastLsu) begin
        lr = 5'($urandom_range(1, 31)); ld = $urandom;
      end
    end
    checkOutput("t3_alu_wins", 64'(aluWins), 64'd4);
    checkOutput("t3_alu_max_wait", 64'(maxWait), 64'd3);
    applyStimulus(1'b0, '0, '0, 1'b1, lr, ld, 1'b0);
    idle();

    // Flush blocks acceptance and clears starvation history
    applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd4, 32'hB, 1'b0);
    applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd5, 32'hC, 1'b0);
    applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd6, 32'hD, 1'b1);
    checkOutput("t5_flush_we", 64'(rf_we), 64'd0);
    aluWins = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd6, 32'hD + 32'(i), 1'b0);
    end
    checkOutput("t5_lsu_after_flush", 64'(aluWins), 64'd0);
    applyStimulus(1'b1, 5'd3, 32'hA, 1'b1, 5'd6, 32'h10, 1'b0);
    checkOutput("t5_alu_4th", 64'(lastAlu), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd6, 32'h10, 1'b0);
    idle();

    // Same destination on consecutive cycles: later write wins
    applyStimulus(1'b1, 5'd9, 32'd1, 1'b0, '0, '0, 1'b0);
    w1 = rf_we;
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd9, 32'd2, 1'b0);
    w2 = rf_we;
    checkOutput("t6_we_pair", 64'({w1, w2}), 64'd3);
    idle();
    idle();
    checkOutput("t6_x9", 64'(rfArr[9]), 64'd2);

    // Reset mid-transfer with a nonzero starvation count
    applyStimulus(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t1_we", 64'(rf_we), 64'd0);
    checkOutput("t1_addr", 64'(rf_wr_addr), 64'd0);
    checkOutput("t1_data", 64'(rf_wr_data), 64'd0);
    checkOutput("t1_src", 64'(wb_src), 64'd0);
    scoreQ.delete();
    mStarve = 0; expAddr = '0; expData = '0; expSrc = 1'b0;
    @(posedge clk); #1;
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    aluWins = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h70 + 32'(i), 1'b0);
    end
    checkOutput("t1_starve_cleared", 64'(aluWins), 64'd1);
    checkOutput("t1_alu_last", 64'(lastAlu), 64'd1);
    applyStimulus(1'b0, '0, '0, 1'b1, 5'd6, 32'h73, 1'b0);
    idle();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
